// File: rtl/ucie_ctl_sb_pkg.sv
// Shared sideband definitions: word layout, header field widths and TX framer states.
package ucie_ctl_sb_pkg;

  localparam int SB_WORD_W = 64;
  localparam int SB_CP_BIT = 63;
  localparam int SB_DP_BIT = 62;
  localparam int PH0_W     = 32;
  localparam int PH1_W     = 30;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } sb_tx_state_e;

  // Header word: cp at the top, dp below it, then phase1 and phase0.
  function automatic logic [SB_WORD_W-1:0] sb_pack_header(
    input logic             cp,
    input logic             dp,
    input logic [PH1_W-1:0] ph1,
    input logic [PH0_W-1:0] ph0
  );
    logic [SB_WORD_W-1:0] w;
    w                = '0;
    w[PH0_W-1:0]     = ph0;
    w[PH0_W+:PH1_W]  = ph1;
    w[SB_DP_BIT]     = dp;
    w[SB_CP_BIT]     = cp;
    return w;
  endfunction

endpackage

// File: rtl/ucie_ctl_sb_gap_timer.sv
// 4-bit down-counter that times the idle gap between sideband packets.
module ucie_ctl_sb_gap_timer (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  output logic       o_expired
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expired = (cnt_q == 4'd0);

endmodule

// File: rtl/ucie_ctl_sb_tx_framer.sv
// Sideband TX framer: captures one packet, emits header then optional data word, then idles GAP_CYCLES.
// Optional parity error injection is enabled by defining UCIE_CTL_SB_ERR_INJ_EN.
module ucie_ctl_sb_tx_framer
  import ucie_ctl_sb_pkg::*;
#(
  parameter int GAP_CYCLES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_pkt_valid,
  output logic                 o_pkt_ready,
  input  logic [PH0_W-1:0]     i_concat_phase0,
  input  logic [PH1_W-1:0]     i_concat_phase1,
  input  logic [SB_WORD_W-1:0] i_data,
  input  logic                 i_has_data,
  input  logic                 i_dp,
  input  logic                 i_cp,
`ifdef UCIE_CTL_SB_ERR_INJ_EN
  input  logic                 i_inj_dp_err,
  input  logic                 i_inj_cp_err,
`endif
  output logic [SB_WORD_W-1:0] o_sb_word,
  output logic                 o_sb_valid,
  input  logic                 i_sb_ready,
  output logic                 o_pkt_done,
  output logic                 o_busy
);

  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
  localparam bit         HAS_GAP  = (GAP_CYCLES != 0);

  sb_tx_state_e         state_q;
  logic [SB_WORD_W-1:0] data_q;
  logic                 has_data_q;
  logic [SB_WORD_W-1:0] word_q;
  logic                 valid_q;
  logic                 done_q;
  logic                 ready_q;

  logic accept;
  logic last_hs;
  logic gap_load;
  logic gap_expired;
  logic dp_cap;
  logic cp_cap;

`ifdef UCIE_CTL_SB_ERR_INJ_EN
  assign dp_cap = i_dp ^ i_inj_dp_err;
  assign cp_cap = i_cp ^ i_inj_cp_err;
`else
  assign dp_cap = i_dp;
  assign cp_cap = i_cp;
`endif

  assign accept   = i_pkt_valid & ready_q;
  // Handshake on the final word of the packet: header without data, or the data word.
  assign last_hs  = valid_q & i_sb_ready &
                    (((state_q == HDR) & ~has_data_q) | (state_q == DATA));
  assign gap_load = last_hs & HAS_GAP;

  ucie_ctl_sb_gap_timer u_gap_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (gap_load),
    .i_load_val (GAP_LOAD),
    .o_expired  (gap_expired)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      data_q     <= '0;
      has_data_q <= 1'b0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      done_q <= last_hs;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q    <= HDR;
            ready_q    <= 1'b0;
            data_q     <= i_data;
            has_data_q <= i_has_data;
            word_q     <= sb_pack_header(cp_cap, dp_cap, i_concat_phase1, i_concat_phase0);
            valid_q    <= 1'b1;
          end else begin
            ready_q <= 1'b1;
          end
        end
        HDR: begin
          if (i_sb_ready) begin
            if (has_data_q) begin
              state_q <= DATA;
              word_q  <= data_q;
            end else begin
              valid_q <= 1'b0;
              word_q  <= '0;
              state_q <= HAS_GAP ? GAP : IDLE;
              ready_q <= !HAS_GAP;
            end
          end
        end
        DATA: begin
          if (i_sb_ready) begin
            valid_q <= 1'b0;
            word_q  <= '0;
            state_q <= HAS_GAP ? GAP : IDLE;
            ready_q <= !HAS_GAP;
          end
        end
        GAP: begin
          if (gap_expired) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_pkt_ready = ready_q;
  assign o_sb_word   = word_q;
  assign o_sb_valid  = valid_q;
  assign o_pkt_done  = done_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ucie_ctl_sb_tx_framer.sv
// Self-checking bench for ucie_ctl_sb_tx_framer (GAP_CYCLES=2 and GAP_CYCLES=0 instances).
module tb_ucie_ctl_sb_tx_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_pkt_valid;
  logic [31:0] i_concat_phase0;
  logic [29:0] i_concat_phase1;
  logic [63:0] i_data;
  logic        i_has_data;
  logic        i_dp;
  logic        i_cp;
  logic        i_sb_ready;
`ifdef UCIE_CTL_SB_ERR_INJ_EN
  logic        i_inj_dp_err;
  logic        i_inj_cp_err;
`endif

  logic        o_pkt_ready, o_sb_valid, o_pkt_done, o_busy;
  logic [63:0] o_sb_word;
  logic        z_pkt_ready, z_sb_valid, z_pkt_done, z_busy;
  logic [63:0] z_sb_word;

  int errors = 0;
  int checks = 0;

  logic [63:0] sbq[$];
  bit          mon_en = 1'b0;

  typedef struct {
    logic [31:0] ph0;
    logic [29:0] ph1;
    logic [63:0] data;
    logic        has_data;
    logic        dp;
    logic        cp;
    logic [63:0] exp_hdr;
  } vec_t;
  vec_t vt[4];

  always #5 clk = ~clk;

  ucie_ctl_sb_tx_framer #(.GAP_CYCLES(2)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_pkt_valid     (i_pkt_valid),
    .o_pkt_ready     (o_pkt_ready),
    .i_concat_phase0 (i_concat_phase0),
    .i_concat_phase1 (i_concat_phase1),
    .i_data          (i_data),
    .i_has_data      (i_has_data),
    .i_dp            (i_dp),
    .i_cp            (i_cp),
`ifdef UCIE_CTL_SB_ERR_INJ_EN
    .i_inj_dp_err    (i_inj_dp_err),
    .i_inj_cp_err    (i_inj_cp_err),
`endif
    .o_sb_word       (o_sb_word),
    .o_sb_valid      (o_sb_valid),
    .i_sb_ready      (i_sb_ready),
    .o_pkt_done      (o_pkt_done),
    .o_busy          (o_busy)
  );

  ucie_ctl_sb_tx_framer #(.GAP_CYCLES(0)) dut0 (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_pkt_valid     (i_pkt_valid),
    .o_pkt_ready     (z_pkt_ready),
    .i_concat_phase0 (i_concat_phase0),
    .i_concat_phase1 (i_concat_phase1),
    .i_data          (i_data),
    .i_has_data      (i_has_data),
    .i_dp            (i_dp),
    .i_cp            (i_cp),
`ifdef UCIE_CTL_SB_ERR_INJ_EN
    .i_inj_dp_err    (i_inj_dp_err),
    .i_inj_cp_err    (i_inj_cp_err),
`endif
    .o_sb_word       (z_sb_word),
    .o_sb_valid      (z_sb_valid),
    .i_sb_ready      (i_sb_ready),
    .o_pkt_done      (z_pkt_done),
    .o_busy          (z_busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted sideband word must match the next queued expectation.
  always @(negedge clk) begin
    if (mon_en && o_sb_valid === 1'b1 && i_sb_ready === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got %h expected no word", o_sb_word);
      end else begin
        chk("sb_word", o_sb_word, sbq.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic send(input int idx, input logic [63:0] exp_hdr);
    int n = 0;
    while (o_pkt_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL pkt_ready_timeout: got 0 expected 1 within 50 cycles");
      return;
    end
    i_concat_phase0 = vt[idx].ph0;
    i_concat_phase1 = vt[idx].ph1;
    i_data          = vt[idx].data;
    i_has_data      = vt[idx].has_data;
    i_dp            = vt[idx].dp;
    i_cp            = vt[idx].cp;
    i_pkt_valid     = 1'b1;
    sbq.push_back(exp_hdr);
    if (vt[idx].has_data) sbq.push_back(vt[idx].data);
    @(posedge clk); #1;
    i_pkt_valid     = 1'b0;
    i_concat_phase0 = $urandom;
    i_concat_phase1 = 30'($urandom);
    i_data          = {$urandom, $urandom};
    i_has_data      = 1'($urandom);
    i_dp            = 1'($urandom);
    i_cp            = 1'($urandom);
  endtask

  task automatic wait_done();
    int  n = 0;
    bit  seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      if (o_pkt_done === 1'b1) seen = 1'b1;
      n++;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL pkt_done_timeout: got 0 expected 1 within 60 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    logic exp_v[7];
    logic exp_r[7];

    vt[0] = '{32'hDEAD_BEEF, 30'h0,         64'h0,                   1'b0, 1'b0, 1'b1, 64'h8000_0000_DEAD_BEEF};
    vt[1] = '{32'h1111_2222, 30'h3FFF_FFFF, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b1, 1'b0, 64'h7FFF_FFFF_1111_2222};
    vt[2] = '{32'h0000_0000, 30'h2AAA_AAAA, 64'hFFFF_0000_A5A5_5A5A, 1'b1, 1'b1, 1'b1, 64'hEAAA_AAAA_0000_0000};
    vt[3] = '{32'hCAFE_F00D, 30'h0000_1234, 64'h0,                   1'b0, 1'b0, 1'b0, 64'h0000_1234_CAFE_F00D};

    rst = 1'b0; i_pkt_valid = 1'b0; i_concat_phase0 = '0; i_concat_phase1 = '0;
    i_data = '0; i_has_data = 1'b0; i_dp = 1'b0; i_cp = 1'b0; i_sb_ready = 1'b1;
`ifdef UCIE_CTL_SB_ERR_INJ_EN
    i_inj_dp_err = 1'b0; i_inj_cp_err = 1'b0;
`endif

    // Reset values
    repeat (2) @(posedge clk);
    #1 i_pkt_valid = 1'b1;
    @(negedge clk);
    chk1("rst_sb_valid", o_sb_valid, 1'b0);
    chk("rst_sb_word", o_sb_word, 64'h0);
    chk1("rst_pkt_done", o_pkt_done, 1'b0);
    chk1("rst_busy", o_busy, 1'b0);
    chk1("rst_pkt_ready", o_pkt_ready, 1'b0);
    @(posedge clk); #1;
    i_pkt_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk1("rel_pkt_ready_early", o_pkt_ready, 1'b0);
    @(posedge clk); #1;
    chk1("rel_pkt_ready", o_pkt_ready, 1'b1);
    mon_en = 1'b1;

    // Case 1: no-data packet timing
    send(0, vt[0].exp_hdr);
    chk1("c1_valid", o_sb_valid, 1'b1);
    chk("c1_word", o_sb_word, vt[0].exp_hdr);
    chk1("c1_ready_low", o_pkt_ready, 1'b0);
    @(posedge clk); #1;
    chk1("c1_valid_off", o_sb_valid, 1'b0);
    chk("c1_word_zero", o_sb_word, 64'h0);
    chk1("c1_done", o_pkt_done, 1'b1);
    chk1("c1_busy_gap", o_busy, 1'b1);
    chk1("c1_gap1_ready", o_pkt_ready, 1'b0);
    @(posedge clk); #1;
    chk1("c1_done_pulse", o_pkt_done, 1'b0);
    chk1("c1_gap2_ready", o_pkt_ready, 1'b0);
    @(posedge clk); #1;
    chk1("c1_ready_back", o_pkt_ready, 1'b1);
    chk1("c1_busy_idle", o_busy, 1'b0);

    // Table of packets through the scoreboard
    for (int i = 0; i < 4; i++) begin
      send(i, vt[i].exp_hdr);
      wait_done();
      chk("tbl_sbq_empty", 64'(sbq.size()), 64'h0);
    end

    // Case 3: backpressure in HDR, with a competing offer
    repeat (3) @(posedge clk);
    #1 i_sb_ready = 1'b0;
    send(1, vt[1].exp_hdr);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk1("bp_valid", o_sb_valid, 1'b1);
      chk("bp_word", o_sb_word, vt[1].exp_hdr);
      chk1("bp_pkt_ready", o_pkt_ready, 1'b0);
      @(posedge clk); #1;
      i_pkt_valid     = 1'b1;
      i_concat_phase0 = $urandom;
    end
    i_pkt_valid = 1'b0;
    i_sb_ready  = 1'b1;
    wait_done();
    repeat (4) @(posedge clk);
    #1;
    chk1("bp_idle_after", o_busy, 1'b0);
    chk("bp_sbq_empty", 64'(sbq.size()), 64'h0);

    // Case 4: reset while in DATA
    send(1, vt[1].exp_hdr);
    @(posedge clk); #1;
    i_sb_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk1("rd_in_data", o_sb_valid, 1'b1);
    chk("rd_data_word", o_sb_word, vt[1].data);
    @(posedge clk); #1;
    rst = 1'b1;
    i_sb_ready = 1'b1;
    sbq.delete();
    chk1("rd_valid", o_sb_valid, 1'b0);
    chk1("rd_busy", o_busy, 1'b0);
    chk("rd_word", o_sb_word, 64'h0);
    chk1("rd_ready_in_rst", o_pkt_ready, 1'b0);
    @(posedge clk); #1;
    chk1("rd_ready_back", o_pkt_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("rd_no_stale", o_sb_valid, 1'b0);
    end
    @(posedge clk); #1;

    // Case 5: GAP_CYCLES=0 back-to-back offers
    mon_en = 1'b0;
    do_reset(2);
    i_concat_phase0 = vt[0].ph0; i_concat_phase1 = vt[0].ph1; i_data = vt[0].data;
    i_has_data = vt[0].has_data; i_dp = vt[0].dp; i_cp = vt[0].cp;
    i_pkt_valid = 1'b1;
    exp_v = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_r = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    acc = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (i_pkt_valid && z_pkt_ready) acc++;
      chk1("g0_sb_valid", z_sb_valid, exp_v[k]);
      chk1("g0_pkt_ready", z_pkt_ready, exp_r[k]);
      if (exp_v[k]) chk("g0_word", z_sb_word, vt[0].exp_hdr);
      @(posedge clk); #1;
      if (k == 4) i_pkt_valid = 1'b0;
    end
    chk("g0_accepts", 64'(acc), 64'd3);

    // Re-sync the GAP_CYCLES=2 instance before further scoreboard use
    do_reset(2);
    sbq.delete();
    mon_en = 1'b1;

`ifdef UCIE_CTL_SB_ERR_INJ_EN
    // Case 6: cp error injection affects only one packet
    i_inj_cp_err = 1'b1;
    send(0, 64'h0000_0000_DEAD_BEEF);
    i_inj_cp_err = 1'b0;
    wait_done();
    send(0, vt[0].exp_hdr);
    wait_done();
    i_inj_dp_err = 1'b1;
    send(3, 64'h4000_1234_CAFE_F00D);
    i_inj_dp_err = 1'b0;
    wait_done();
    chk("inj_sbq_empty", 64'(sbq.size()), 64'h0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("final_sbq_empty", 64'(sbq.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
